// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle datapath: FSM state codes, ALU
// operation codes and immediate-format selectors.
package mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  localparam logic [1:0] IMM_I = 2'd0;
  localparam logic [1:0] IMM_S = 2'd1;
  localparam logic [1:0] IMM_B = 2'd2;
  localparam logic [1:0] IMM_U = 2'd3;

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU: result plus {N,Z,C,V}. C is carry-out on add and
// not-borrow on sub; V is signed overflow for add/sub only.
module mc_alu
  import mc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic [3:0]      flags
);

  localparam int SW = $clog2(XLEN);

  logic [XLEN:0]   sum, diff;
  logic [SW-1:0]   sh;
  logic            c, v;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} + {1'b0, ~b} + {{XLEN{1'b0}}, 1'b1};
    sh     = b[SW-1:0];
    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    case (op)
      ALU_ADD: begin
        result = sum[XLEN-1:0];
        c      = sum[XLEN];
        v      = (a[XLEN-1] == b[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
      end
      ALU_SUB: begin
        result = diff[XLEN-1:0];
        c      = diff[XLEN];
        v      = (a[XLEN-1] != b[XLEN-1]) && (diff[XLEN-1] != a[XLEN-1]);
      end
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << sh;
      ALU_SRL:  result = a >> sh;
      ALU_SRA:  result = XLEN'($signed(a) >>> sh);
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, a < b};
      default:  result = '0;
    endcase
    flags = {result[XLEN-1], result == '0, c, v};
  end

endmodule

// File: rtl/multicycle_datapath.sv
// Multi-cycle core datapath: FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer,
// register file and immediate generator around mc_alu.
module multicycle_datapath
  import mc_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] PC_RESET = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ready,
  input  logic            pcsrc,
  input  logic            alusrc,
  input  logic            mrw,
  input  logic            wb,
  input  logic            regrw,
  input  logic [3:0]      aluop,
  input  logic [1:0]      immgen_ctrl,
  output logic [31:0]     instr,
  output logic [3:0]      status,
  output logic            retire,
  output logic [2:0]      state
);

  localparam int RW = $clog2(NREGS);

  state_t st, st_nxt;

  logic [NREGS-1:0][XLEN-1:0] rf;
  logic [XLEN-1:0] pc, a_q, b_q, imm_q, aluout, mdr;
  logic [XLEN-1:0] imm_w, op2, alu_res, wb_data;
  logic [3:0]      alu_flags, aluop_q;
  logic            pcsrc_q, alusrc_q, mrw_q, wb_q, regrw_q;
  logic [RW-1:0]   rs1, rs2, rd;

  assign rs1 = instr[15 +: RW];
  assign rs2 = instr[20 +: RW];
  assign rd  = instr[7 +: RW];

  // Immediate is built from the instruction register during DECODE.
  always_comb begin
    imm_w = '0;
    case (immgen_ctrl)
      IMM_I: imm_w = XLEN'($signed(instr[31:20]));
      IMM_S: imm_w = XLEN'($signed({instr[31:25], instr[11:7]}));
      IMM_B: imm_w = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      IMM_U: imm_w = XLEN'($signed({instr[31:12], 12'b0}));
      default: imm_w = '0;
    endcase
  end

  assign op2     = alusrc_q ? imm_q : b_q;
  assign wb_data = wb_q ? aluout : mdr;

  mc_alu #(.XLEN(XLEN)) u_alu (
    .op     (aluop_q),
    .a      (a_q),
    .b      (op2),
    .result (alu_res),
    .flags  (alu_flags)
  );

  always_comb begin
    st_nxt   = st;
    dmem_req = 1'b0;
    retire   = 1'b0;
    case (st)
      S_FETCH:     st_nxt = S_DECODE;
      S_DECODE:    st_nxt = S_EXECUTE;
      S_EXECUTE:   st_nxt = (mrw_q | ~wb_q) ? S_MEM : S_WRITEBACK;
      S_MEM: begin
        dmem_req = 1'b1;
        if (dmem_ready) st_nxt = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        retire = 1'b1;
        st_nxt = S_FETCH;
      end
      default:     st_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) st <= S_FETCH;
    else       st <= st_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= PC_RESET;
      instr    <= '0;
      status   <= '0;
      rf       <= '0;
      a_q      <= '0;
      b_q      <= '0;
      imm_q    <= '0;
      aluout   <= '0;
      mdr      <= '0;
      aluop_q  <= '0;
      pcsrc_q  <= 1'b0;
      alusrc_q <= 1'b0;
      mrw_q    <= 1'b0;
      wb_q     <= 1'b0;
      regrw_q  <= 1'b0;
    end else begin
      case (st)
        S_FETCH: instr <= imem_rdata;
        S_DECODE: begin
          a_q      <= rf[rs1];
          b_q      <= rf[rs2];
          imm_q    <= imm_w;
          aluop_q  <= aluop;
          pcsrc_q  <= pcsrc;
          alusrc_q <= alusrc;
          mrw_q    <= mrw;
          wb_q     <= wb;
          regrw_q  <= regrw;
        end
        S_EXECUTE: begin
          aluout <= alu_res;
          status <= alu_flags;
        end
        S_MEM: if (dmem_ready) mdr <= dmem_rdata;
        S_WRITEBACK: begin
          // x0 is never written, so its reset value keeps it reading zero.
          if (regrw_q && rd != '0) rf[rd] <= wb_data;
          pc <= pcsrc_q ? pc + imm_q : pc + XLEN'(4);
        end
        default: ;
      endcase
    end
  end

  assign imem_addr  = pc;
  assign dmem_we    = mrw_q;
  assign dmem_addr  = aluout;
  assign dmem_wdata = b_q;
  assign state      = st;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench: an instruction-level model predicts a per-cycle trace
// that one compare process checks on every falling edge.
module tb_multicycle_datapath;

  logic        clk = 1'b0, reset = 1'b1;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, instr;
  logic        dmem_req, dmem_we, dmem_ready, retire;
  logic        pcsrc, alusrc, mrw, wb, regrw;
  logic [3:0]  aluop, status;
  logic [1:0]  immgen_ctrl;
  logic [2:0]  state;

  multicycle_datapath dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .pcsrc(pcsrc), .alusrc(alusrc), .mrw(mrw), .wb(wb), .regrw(regrw),
    .aluop(aluop), .immgen_ctrl(immgen_ctrl), .instr(instr), .status(status),
    .retire(retire), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  st;
    logic        ret, req, we, rdy;
    logic [31:0] addr, wdata, rdata, pc, ins;
    logic [3:0]  status;
  } cyc_t;

  cyc_t        exp_q[$];
  logic [31:0] m_regs[32];
  logic [31:0] m_pc, m_ins;
  logic [3:0]  m_status;
  int          tests = 0, fails = 0, req_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("state",    32'(state),    32'(e.st));
      chk("retire",   32'(retire),   32'(e.ret));
      chk("dmem_req", 32'(dmem_req), 32'(e.req));
      chk("pc",       imem_addr,     e.pc);
      chk("status",   32'(status),   32'(e.status));
      chk("instr",    instr,         e.ins);
      if (e.req) begin
        chk("dmem_we",    32'(dmem_we), 32'(e.we));
        chk("dmem_addr",  dmem_addr,    e.addr);
        chk("dmem_wdata", dmem_wdata,   e.wdata);
      end
    end
    if (dmem_req) req_cnt++;
  end

  function automatic logic [31:0] m_imm(input logic [31:0] w, input logic [1:0] f);
    case (f)
      2'd0:    return {{20{w[31]}}, w[31:20]};
      2'd1:    return {{20{w[31]}}, w[31:25], w[11:7]};
      2'd2:    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      default: return {w[31:12], 12'b0};
    endcase
  endfunction

  task automatic m_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic [3:0] fl);
    longint sa, sb, s;
    logic   c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = 1'b0; v = 1'b0; s = 0;
    case (op)
      4'd0: begin r = a + b; c = (64'(a) + 64'(b)) > 64'hFFFF_FFFF; s = sa + sb;
                  v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd1: begin r = a - b; c = (a >= b); s = sa - sb;
                  v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << b[4:0];
      4'd6: r = a >> b[4:0];
      4'd7: r = 32'($signed(a) >>> b[4:0]);
      4'd8: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd9: r = (a < b) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    fl = {r[31], r == 32'd0, c, v};
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rd, rs1, rs2);
    return {7'b0, rs2, rs1, 3'b0, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(input logic [4:0] rd, rs1, input logic [11:0] imm, input logic [6:0] opc);
    return {imm, rs1, 3'b010, rd, opc};
  endfunction
  function automatic logic [31:0] enc_s(input logic [4:0] rs1, rs2, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd0, 5'd0, 3'b0, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, 7'h37};
  endfunction

  // Runs one instruction starting in a FETCH cycle (called at posedge+1).
  task automatic run(input logic [31:0] w, input logic [1:0] fmt,
                     input logic ps, as, mw, wbs, rw, input logic [3:0] op,
                     input int waits, input logic [31:0] rdv);
    cyc_t        tr[$];
    cyc_t        c;
    logic [31:0] a, b, imm, res;
    logic [3:0]  fl;
    int          rs1, rs2, rd;
    rs1 = int'(w[19:15]); rs2 = int'(w[24:20]); rd = int'(w[11:7]);
    imm = m_imm(w, fmt);
    a = m_regs[rs1]; b = m_regs[rs2];
    m_alu(op, a, as ? imm : b, res, fl);
    c = '{default: '0};
    c.rdy = 1'b1; c.pc = m_pc; c.status = m_status; c.ins = m_ins;
    tr.push_back(c);
    c.ins = w; c.st = 3'd1; tr.push_back(c);
    c.st = 3'd2; tr.push_back(c);
    c.status = fl;
    if (mw | ~wbs) begin
      for (int k = 0; k <= waits; k++) begin
        c.st = 3'd3; c.req = 1'b1; c.we = mw; c.addr = res; c.wdata = b;
        c.rdy = (k == waits); c.rdata = rdv;
        tr.push_back(c);
      end
      c.req = 1'b0; c.we = 1'b0; c.rdy = 1'b1;
    end
    c.st = 3'd4; c.ret = 1'b1; tr.push_back(c);
    if (rw && rd != 0) m_regs[rd] = wbs ? res : rdv;
    m_pc = ps ? m_pc + imm : m_pc + 32'd4;
    m_status = fl; m_ins = w;
    imem_rdata = w; immgen_ctrl = fmt; pcsrc = ps; alusrc = as;
    mrw = mw; wb = wbs; regrw = rw; aluop = op;
    foreach (tr[k]) exp_q.push_back(tr[k]);
    foreach (tr[k]) begin
      dmem_ready = tr[k].rdy;
      dmem_rdata = tr[k].rdy ? tr[k].rdata : 32'hDEAD_BEEF;
      @(posedge clk); #1;
    end
    dmem_ready = 1'b0;
    for (int i = 0; i < 16; i++) chk($sformatf("x%0d", i), dut.rf[i], m_regs[i]);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_pc = 32'd0; m_ins = 32'd0; m_status = 4'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "timeout");
  end

  initial begin
    imem_rdata = 0; dmem_rdata = 0; dmem_ready = 0; pcsrc = 0; alusrc = 0;
    mrw = 0; wb = 0; regrw = 0; aluop = 0; immgen_ctrl = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pc", imem_addr, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_retire", 32'(retire), 32'd0);
    reset = 1'b0;

    run(enc_i(1, 0, 12'd5, 7'h13), 2'd0, 0, 1, 0, 1, 1, 4'd0, 0, 0);   // addi x1,x0,5
    chk("lit_pc4", imem_addr, 32'd4);
    run(enc_r(2, 1, 1), 2'd0, 0, 0, 0, 1, 1, 4'd0, 0, 0);               // add x2,x1,x1
    chk("lit_x2", dut.rf[2], 32'd10);
    chk("lit_pc8", imem_addr, 32'd8);
    run(enc_r(3, 1, 1), 2'd0, 0, 0, 0, 1, 1, 4'd1, 0, 0);               // sub x3,x1,x1
    chk("lit_sub_flags", 32'(status), 32'b0110);
    run(enc_u(5, 20'h80000), 2'd3, 0, 1, 0, 1, 1, 4'd0, 0, 0);          // lui x5
    run(enc_i(5, 5, 12'hFFF, 7'h13), 2'd0, 0, 1, 0, 1, 1, 4'd0, 0, 0);  // x5 = 0x7FFFFFFF
    run(enc_i(6, 5, 12'd1, 7'h13), 2'd0, 0, 1, 0, 1, 1, 4'd0, 0, 0);    // add overflow
    chk("lit_ovf_flags", 32'(status), 32'b1001);
    chk("lit_x6", dut.rf[6], 32'h8000_0000);
    req_cnt = 0;
    run(enc_s(0, 2, 12'd8), 2'd1, 0, 1, 1, 0, 0, 4'd0, 3, 0);           // sw x2,8(x0)
    chk("lit_sw_req_cycles", req_cnt, 32'd4);
    run(enc_i(4, 0, 12'd8, 7'h03), 2'd0, 0, 1, 0, 0, 1, 4'd0, 1, 32'd10); // lw x4,8(x0)
    chk("lit_x4", dut.rf[4], 32'd10);
    run(enc_i(0, 0, 12'd7, 7'h13), 2'd0, 0, 1, 0, 1, 1, 4'd0, 0, 0);    // write to x0
    chk("lit_x0", dut.rf[0], 32'd0);
    run(enc_b(13'h1FDC), 2'd2, 1, 0, 0, 1, 0, 4'd1, 0, 0);              // pc 36 -> 0
    chk("lit_br36", imem_addr, 32'd0);
    run(enc_i(0, 0, 12'd0, 7'h13), 2'd0, 0, 1, 0, 1, 0, 4'd0, 0, 0);
    run(enc_i(0, 0, 12'd0, 7'h13), 2'd0, 0, 1, 0, 1, 0, 4'd0, 0, 0);
    run(enc_b(13'h1FF8), 2'd2, 1, 0, 0, 1, 0, 4'd1, 0, 0);              // pc 8 -> 0
    chk("lit_br8", imem_addr, 32'd0);
    run(enc_b(13'h1FFC), 2'd2, 1, 0, 0, 1, 0, 4'd1, 0, 0);              // pc 0 wraps
    chk("lit_wrap", imem_addr, 32'hFFFF_FFFC);
    run(enc_r(9, 6, 1), 2'd0, 0, 0, 0, 1, 1, 4'd8, 0, 0);               // slt
    chk("lit_slt", dut.rf[9], 32'd1);
    chk("lit_wrap0", imem_addr, 32'd0);
    run(enc_i(10, 6, 12'd4, 7'h13), 2'd0, 0, 1, 0, 1, 1, 4'd7, 0, 0);   // srai 4
    chk("lit_sra", dut.rf[10], 32'hF800_0000);
    run(enc_r(11, 6, 1), 2'd0, 0, 0, 0, 1, 1, 4'd9, 0, 0);              // sltu

    // Abandon a stalled store by resetting in the middle of MEM.
    imem_rdata = enc_s(0, 2, 12'd8); immgen_ctrl = 2'd1; pcsrc = 0; alusrc = 1;
    mrw = 1; wb = 0; regrw = 0; aluop = 4'd0; dmem_ready = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("mem_req_high", 32'(dmem_req), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("rstmem_req", 32'(dmem_req), 32'd0);
    chk("rstmem_state", 32'(state), 32'd0);
    chk("rstmem_pc", imem_addr, 32'd0);
    chk("rstmem_status", 32'(status), 32'd0);
    chk("rstmem_retire", 32'(retire), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    chk("rstmem_x2", dut.rf[2], 32'd0);
    run(enc_i(1, 0, 12'd5, 7'h13), 2'd0, 0, 1, 0, 1, 1, 4'd0, 0, 0);
    chk("lit_restart_pc", imem_addr, 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
